updown_mod_counter: RTL
=======================

// Module: updown_mod_counter
// PURPOSE
//   Parametrised up/down modulo counter with synchronous load, clock-enable
//   prescaler and wrap/terminal-count flags. Next-generation replacement for
//   the fixed 8-bit loadable counter; used as a timebase/event counter in
//   lab datapaths. Single clock domain, no handshake.
// PARAMETERS
//   WIDTH      8              count/data width in bits (>=2)
//   MAX_COUNT  2**WIDTH-1     highest count value; modulus = MAX_COUNT+1 (1..2**WIDTH-1)
//   PRESCALE   1              clocks per count step while enabled (>=1; 1 = every clock)
// PORTS
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous, active-low reset
//   enable  in   1      count enable; advances prescaler/count when high
//   load    in   1      synchronous load strobe
//   up_dn   in   1      direction: 1 = up, 0 = down
//   data    in   WIDTH  load value
//   count   out  WIDTH  current count (registered)
//   tc      out  1      terminal count: combinational decode of count/up_dn
//   wrap    out  1      registered one-clock pulse on boundary step
// BEHAVIOUR
//   - reset low: count=0, wrap=0, prescaler=0 immediately (no clock edge
//     needed); held while low. tc then follows decode (1 if up_dn=0).
//   - Priority at posedge clk: reset > load > enable > hold.
//   - load=1: count <= (data > MAX_COUNT) ? MAX_COUNT : data; prescaler <= 0;
//     wrap <= 0. Load ignores enable and up_dn. Latency 1 clock.
//   - enable=1, load=0: prescaler increments; on prescaler==PRESCALE-1 (step
//     tick) prescaler <= 0 and count steps once. PRESCALE=1: step every clock.
//   - Step up: count==MAX_COUNT -> 0 and wrap<=1; else count+1, wrap<=0.
//   - Step down: count==0 -> MAX_COUNT and wrap<=1; else count-1, wrap<=0.
//   - Non-step clock (enable=0 or prescaler mid-phase): count holds, wrap<=0.
//   - enable=0 freezes prescaler phase; resumes from same phase.
//   - tc = up_dn ? (count==MAX_COUNT) : (count==0); changes with up_dn
//     same cycle. up_dn is sampled only on step ticks.
//   - Arithmetic is WIDTH bits; count never exceeds MAX_COUNT.
//   - reset asserted mid-prescale discards phase; first step after release
//     occurs PRESCALE enabled clocks later.
// CONFIGURATION
//   CNT_SATURATE_EN defined: boundary step does not wrap; count holds at
//     MAX_COUNT (up) or 0 (down); wrap pulses for each blocked step tick
//     (overflow/underflow indication). Load/reset unchanged.
//   CNT_SATURATE_EN undefined: modulo wrap as above (default).
// TESTING
//   1 Defaults; count running at 8'h37, drive reset low between edges ->
//     count=0, wrap=0 before next edge; holds 0 over 3 clocks while low.
//   2 Defaults, load data=8'hFA, then enable=1 up_dn=1 -> FB,FC,FD,FE,FF
//     (tc=1 at FF), then 00 with wrap=1 for exactly one clock, then 01.
//   3 MAX_COUNT=9: load 2, up_dn=0 -> 1,0(tc=1),9(wrap=1),8; load
//     data=15 -> count=9.
//   4 PRESCALE=4, load 0, enable=1 up -> count 1 after 4 clocks, 2 after 8;
//     enable=0 for 3 clocks mid-phase -> count/phase frozen, resume intact.
//   5 load=1 with enable=1, data=8'h10 -> count=10 next edge (no +1);
//     load=1 with enable=0 -> count=10 likewise.
//   6 CNT_SATURATE_EN, load FE, enable up -> FF, FF (wrap=1), FF (wrap=1);
//     up_dn=0 -> FE, wrap=0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// -----------------------------------------------------------------------------
// updown_mod_counter
//
// Parametrised up/down modulo counter with synchronous load, a clock-enable
// prescaler and terminal-count / wrap flags. Used as a timebase or event
// counter in lab datapaths. Single clock domain, no handshake.
//
// Parameters
//   WIDTH      count/data width in bits (>= 2)
//   MAX_COUNT  highest count value; modulus is MAX_COUNT+1 (1 .. 2**WIDTH-1)
//   PRESCALE   enabled clocks per count step (>= 1; 1 steps on every clock)
//
// Ports
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous, active-low reset
//   enable  in   1      count enable; advances prescaler/count when high
//   load    in   1      synchronous load strobe (beats enable)
//   up_dn   in   1      direction: 1 = up, 0 = down (sampled on step ticks)
//   data    in   WIDTH  load value, clamped to MAX_COUNT
//   count   out  WIDTH  current count (registered)
//   tc      out  1      terminal count, combinational decode of count/up_dn
//   wrap    out  1      registered one-clock pulse on a boundary step
//
// Configuration macro
//   CNT_SATURATE_EN  when defined, a boundary step holds the count at
//                    MAX_COUNT (up) or 0 (down) instead of wrapping; wrap
//                    still pulses for every blocked step tick. Undefined
//                    (default) gives modulo wrap-around.
// -----------------------------------------------------------------------------
module updown_mod_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // Prescaler needs at least one bit even when PRESCALE == 1 (it then stays 0).
  localparam int unsigned    PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX_COUNT);
  localparam logic [PreW-1:0]  PreLast = PreW'(PRESCALE - 1);
  localparam logic [PreW-1:0]  PreOne  = PreW'(1);
  localparam logic [WIDTH-1:0] CntOne  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PreW-1:0]  presc_q, presc_d;
  logic             wrap_q, wrap_d;

  logic at_max;
  logic at_zero;
  logic step;

  assign at_max  = (count_q == MaxVal);
  assign at_zero = (count_q == '0);

  // A step tick is the last enabled clock of a prescaler period.
  assign step = enable & (presc_q == PreLast);

  // Next-state: load > enable > hold. wrap defaults low so it is a single-clock
  // pulse on every clock that is not a boundary step.
  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;

    if (load) begin
      presc_d = '0;
      count_d = (data > MaxVal) ? MaxVal : data;
    end else if (enable) begin
      if (step) begin
        presc_d = '0;
        if (up_dn) begin
          if (at_max) begin
            wrap_d = 1'b1;
`ifdef CNT_SATURATE_EN
            count_d = MaxVal;
`else
            count_d = '0;
`endif
          end else begin
            count_d = count_q + CntOne;
          end
        end else begin
          if (at_zero) begin
            wrap_d = 1'b1;
`ifdef CNT_SATURATE_EN
            count_d = '0;
`else
            count_d = MaxVal;
`endif
          end else begin
            count_d = count_q - CntOne;
          end
        end
      end else begin
        presc_d = presc_q + PreOne;
      end
    end
    // enable low: prescaler phase and count are frozen.
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  // Terminal count follows up_dn in the same cycle, not only on step ticks.
  assign tc    = up_dn ? at_max : at_zero;

endmodule
